// File: rtl/psd_stream_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// psd_stream_pkg
// Shared definitions for the byte-stream arbiter: FSM state encoding,
// header tag nibble and the default maximum packet length.
// No ports.
// ----------------------------------------------------------------------------
package psd_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [3:0] HDR_TAG         = 4'hA;
    localparam int         DEFAULT_MAX_LEN = 255;

endpackage

// File: rtl/psd_stream_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority selector. Searches req starting at
// last+1 (modulo NUM_CH) and returns the first requesting index.
// Ports:
//   req  - per-channel request vector
//   last - index granted most recently
//   hit  - at least one request is present
//   idx  - selected channel index (holds last when hit is low)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        last,
    output logic              hit,
    output logic [1:0]        idx
);

    logic [1:0] cand;

    always_comb begin
        hit  = 1'b0;
        idx  = last;
        cand = last;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = 2'((int'(last) + k) % NUM_CH);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/psd_stream_arbiter.sv
// ----------------------------------------------------------------------------
// psd_stream_arbiter
// Round-robin arbiter merging NUM_CH byte streams into one AXI-Stream FIFO.
// Each packet is prefixed with a header byte {HDR_TAG, 2'b00, grant}.
// Packets longer than MAX_LEN are truncated (forced tlast), the remainder
// is drained from the source and ovf_flag is set.
// Ports:
//   clk, reset           - system clock, async active-high reset
//   s_tdata/tvalid/tlast - per-channel source streams (channel i at [8i+7:8i])
//   s_tready             - per-channel ready
//   m_tdata/tvalid/tlast - FIFO-side stream, m_tready from the FIFO
//   clear_ovf            - pulse clearing ovf_flag (a coincident set wins)
//   grant                - channel currently owning the FIFO
//   busy                 - FSM not in IDLE
//   ovf_flag             - sticky truncation flag
//   pkt_count            - packets emitted, wraps at 16 bits
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no owner; pick next requester round-robin
// ST_HEADER | emit header byte for the granted channel
// ST_DATA   | pass-through of the granted channel to the FIFO
// ST_DRAIN  | truncated packet: swallow source bytes up to its tlast
// ----------------------------------------------------------------------------
module psd_stream_arbiter
    import psd_stream_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*NUM_CH-1:0]   s_tdata,
    input  logic [NUM_CH-1:0]     s_tvalid,
    input  logic [NUM_CH-1:0]     s_tlast,
    output logic [NUM_CH-1:0]     s_tready,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    input  logic                  clear_ovf,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  ovf_flag,
    output logic [15:0]           pkt_count
);

    state_t     state, state_nx;
    logic [1:0] last_grant;
    logic [7:0] beat_cnt;
    logic       pick_hit;
    logic [1:0] pick_idx;
    logic       at_max;
    logic       ld_grant, inc_cnt, inc_pkt, set_ovf, upd_lg;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .req  (s_tvalid),
        .last (last_grant),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

    // beat_cnt holds beats already accepted, so the MAX_LEN-th beat is the
    // one presented while beat_cnt == MAX_LEN-1.
    assign at_max = (beat_cnt == 8'(MAX_LEN - 1));
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'(NUM_CH - 1);
            beat_cnt   <= 8'd0;
            pkt_count  <= 16'd0;
            ovf_flag   <= 1'b0;
        end else begin
            state <= state_nx;
            if (ld_grant) begin
                grant    <= pick_idx;
                beat_cnt <= 8'd0;
            end else if (inc_cnt) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (upd_lg)
                last_grant <= grant;
            if (inc_pkt)
                pkt_count <= pkt_count + 16'd1;
            if (set_ovf)
                ovf_flag <= 1'b1;
            else if (clear_ovf)
                ovf_flag <= 1'b0;
        end
    end

    // m_tvalid and m_tlast never depend on m_tready; only the handshake
    // side effects (counters, state change) do.
    always_comb begin
        state_nx = state;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = 8'h00;
        s_tready = '0;
        ld_grant = 1'b0;
        inc_cnt  = 1'b0;
        inc_pkt  = 1'b0;
        set_ovf  = 1'b0;
        upd_lg   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_hit) begin
                    ld_grant = 1'b1;
                    state_nx = ST_HEADER;
                end
            end
            ST_HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = {HDR_TAG, 2'b00, grant};
                if (m_tready)
                    state_nx = ST_DATA;
            end
            ST_DATA: begin
                m_tdata         = s_tdata[{grant, 3'b000} +: 8];
                m_tvalid        = s_tvalid[grant];
                m_tlast         = s_tvalid[grant] & (s_tlast[grant] | at_max);
                s_tready[grant] = m_tready;
                if (m_tvalid && m_tready) begin
                    inc_cnt = 1'b1;
                    if (s_tlast[grant]) begin
                        inc_pkt  = 1'b1;
                        upd_lg   = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (at_max) begin
                        inc_pkt  = 1'b1;
                        set_ovf  = 1'b1;
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                s_tready[grant] = 1'b1;
                if (s_tvalid[grant] && s_tlast[grant]) begin
                    upd_lg   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_psd_stream_arbiter.sv
module tb_psd_stream_arbiter;

    localparam int NUM_CH  = 4;
    localparam int MAX_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tlast, s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic        clear_ovf;
    logic [1:0]  grant;
    logic        busy, ovf_flag;
    logic [15:0] pkt_count;

    logic [7:0]  d [4];
    logic        v [4];
    logic        l [4];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mirror_err = 0;
    int          bad_rdy  = 0;
    logic        in_data  = 1'b0;
    logic [1:0]  cur_ch   = 2'd0;
    logic [8:0]  got [$];
    logic [15:0] exp_pkt  = 16'd0;

    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign s_tdata[8*i +: 8] = d[i];
        assign s_tvalid[i]       = v[i];
        assign s_tlast[i]        = l[i];
    end

    psd_stream_arbiter #(.NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .clear_ovf (clear_ovf),
        .grant     (grant),
        .busy      (busy),
        .ovf_flag  (ovf_flag),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    // FIFO-side monitor: records accepted beats as {tlast, data} and checks
    // the ready rules against the channel named in the last header.
    always @(negedge clk) begin
        if (reset) begin
            in_data = 1'b0;
        end else begin
            if (in_data && (s_tready !== (m_tready ? (4'b0001 << cur_ch) : 4'b0000)))
                mirror_err++;
            if ((s_tready & ~(4'b0001 << cur_ch)) != 4'b0000)
                bad_rdy++;
            if (m_tvalid && m_tready) begin
                got.push_back({m_tlast, m_tdata});
                if (!in_data) begin
                    in_data = 1'b1;
                    cur_ch  = m_tdata[1:0];
                end else if (m_tlast) begin
                    in_data = 1'b0;
                end
            end
        end
    end

    task automatic send_pkt(input int ch, input int n, input logic [7:0] b [8]);
        int t;
        for (int i = 0; i < n; i++) begin
            d[ch] = b[i];
            v[ch] = 1'b1;
            l[ch] = (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!s_tready[ch] && t < 60) begin
                @(negedge clk);
                t++;
            end
            if (t >= 60) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout ch%0d beat %0d: s_tready stayed 0, required 1", ch, i);
                v[ch] = 1'b0; l[ch] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        v[ch] = 1'b0;
        l[ch] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; m_tready = 1'b1; clear_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin d[i] = 8'h00; v[i] = 1'b0; l[i] = 1'b0; end
        v[2] = 1'b1; d[2] = 8'h5A;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d, expected 0", grant); end
        n_checks++; if ({m_tvalid, m_tlast, m_tdata} !== 10'd0) begin n_fail++; $display("FAIL reset_m_side: got v=%b l=%b d=%h, expected all 0", m_tvalid, m_tlast, m_tdata); end
        n_checks++; if (s_tready !== 4'b0) begin n_fail++; $display("FAIL reset_s_tready: got %b, expected 0000", s_tready); end
        n_checks++; if ({ovf_flag, pkt_count} !== 17'd0) begin n_fail++; $display("FAIL reset_ovf_pkt: got ovf=%b pkt=%h, expected 0/0000", ovf_flag, pkt_count); end
        v[2] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, m_tvalid} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b m_tvalid=%b, expected 0/0", busy, m_tvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_packet;
        logic [7:0] pk [8];
        logic [8:0] ex [$];
        pk = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex = '{9'h0A2, 9'h011, 9'h022, 9'h133};
        got.delete();
        send_pkt(2, 3, pk);
        exp_pkt++;
        @(negedge clk);
        for (int i = 0; i < ex.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== ex[i]) begin n_fail++; $display("FAIL single_beat%0d: got %h, expected %h", i, (i < got.size()) ? got[i] : 9'h1FF, ex[i]); end
        end
        n_checks++; if (got.size() != ex.size()) begin n_fail++; $display("FAIL single_len: got %0d beats, expected %0d", got.size(), ex.size()); end
        n_checks++; if (pkt_count !== exp_pkt) begin n_fail++; $display("FAIL single_pkt_count: got %h, expected %h", pkt_count, exp_pkt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b, expected 0", busy); end
        n_checks++; if (grant !== 2'd2) begin n_fail++; $display("FAIL single_grant: got %0d, expected 2", grant); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        logic [7:0] p0a [8], p0b [8], p1a [8], p1b [8];
        logic [8:0] ex [$];
        p0a = '{8'h50, 0, 0, 0, 0, 0, 0, 0};
        p0b = '{8'h51, 0, 0, 0, 0, 0, 0, 0};
        p1a = '{8'h60, 0, 0, 0, 0, 0, 0, 0};
        p1b = '{8'h61, 0, 0, 0, 0, 0, 0, 0};
        ex  = '{9'h0A0, 9'h150, 9'h0A1, 9'h160, 9'h0A0, 9'h151, 9'h0A1, 9'h161};
        got.delete();
        fork
            begin send_pkt(0, 1, p0a); send_pkt(0, 1, p0b); end
            begin send_pkt(1, 1, p1a); send_pkt(1, 1, p1b); end
        join
        exp_pkt += 16'd4;
        @(negedge clk);
        for (int i = 0; i < ex.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== ex[i]) begin n_fail++; $display("FAIL rr_beat%0d: got %h, expected %h", i, (i < got.size()) ? got[i] : 9'h1FF, ex[i]); end
        end
        n_checks++; if (pkt_count !== exp_pkt) begin n_fail++; $display("FAIL rr_pkt_count: got %h, expected %h", pkt_count, exp_pkt); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        logic [7:0] pk [8];
        logic [8:0] ex [$];
        pk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h00, 8'h00};
        ex = '{9'h0A3, 9'h031, 9'h032, 9'h033, 9'h134};
        got.delete();
        send_pkt(3, 6, pk);
        exp_pkt++;
        @(negedge clk);
        for (int i = 0; i < ex.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== ex[i]) begin n_fail++; $display("FAIL ovf_beat%0d: got %h, expected %h", i, (i < got.size()) ? got[i] : 9'h1FF, ex[i]); end
        end
        n_checks++; if (got.size() != ex.size()) begin n_fail++; $display("FAIL ovf_len: got %0d beats, expected %0d", got.size(), ex.size()); end
        n_checks++; if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, expected 1", ovf_flag); end
        n_checks++; if ({busy, pkt_count} !== {1'b0, exp_pkt}) begin n_fail++; $display("FAIL ovf_idle_pkt: got busy=%b pkt=%h, expected 0/%h", busy, pkt_count, exp_pkt); end
        @(posedge clk); #1; clear_ovf = 1'b1;
        @(posedge clk); #1; clear_ovf = 1'b0;
        @(negedge clk);
        n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, expected 0", ovf_flag); end
        @(posedge clk); #1;
    endtask

    task automatic test_exact_max_len;
        logic [7:0] pa [8], pb [8];
        logic [8:0] ex [$];
        pa = '{8'h41, 8'h42, 8'h43, 8'h44, 0, 0, 0, 0};
        pb = '{8'h45, 0, 0, 0, 0, 0, 0, 0};
        ex = '{9'h0A0, 9'h041, 9'h042, 9'h043, 9'h144, 9'h0A1, 9'h145};
        got.delete();
        send_pkt(0, 4, pa);
        send_pkt(1, 1, pb);
        exp_pkt += 16'd2;
        @(negedge clk);
        for (int i = 0; i < ex.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== ex[i]) begin n_fail++; $display("FAIL exact_beat%0d: got %h, expected %h", i, (i < got.size()) ? got[i] : 9'h1FF, ex[i]); end
        end
        n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL exact_no_ovf: got %b, expected 0", ovf_flag); end
        n_checks++; if (pkt_count !== exp_pkt) begin n_fail++; $display("FAIL exact_pkt_count: got %h, expected %h", pkt_count, exp_pkt); end
        @(posedge clk); #1;
    endtask

    task automatic test_set_wins;
        logic [7:0] pk [8];
        logic [8:0] ex [$];
        int t;
        pk = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 0, 0, 0};
        ex = '{9'h0A2, 9'h021, 9'h022, 9'h023, 9'h124};
        got.delete();
        fork
            send_pkt(2, 5, pk);
            begin
                for (t = 0; t < 60; t++) begin
                    @(negedge clk);
                    if (m_tvalid && m_tready && m_tlast) break;
                end
                if (t >= 60) begin n_checks++; n_fail++; $display("FAIL setwin_timeout: no truncating beat seen, required one"); end
                clear_ovf = 1'b1;
                @(posedge clk); #1;
                clear_ovf = 1'b0;
            end
        join
        exp_pkt++;
        @(negedge clk);
        for (int i = 0; i < ex.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== ex[i]) begin n_fail++; $display("FAIL setwin_beat%0d: got %h, expected %h", i, (i < got.size()) ? got[i] : 9'h1FF, ex[i]); end
        end
        n_checks++; if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL setwin_ovf: got %b, expected 1", ovf_flag); end
        @(posedge clk); #1; clear_ovf = 1'b1;
        @(posedge clk); #1; clear_ovf = 1'b0;
    endtask

    task automatic test_back_pressure;
        logic [7:0] pk [8];
        logic [8:0] ex [$];
        logic       tog_en;
        pk = '{8'h71, 8'h72, 8'h73, 0, 0, 0, 0, 0};
        ex = '{9'h0A0, 9'h071, 9'h072, 9'h173};
        got.delete();
        tog_en = 1'b1;
        fork
            begin send_pkt(0, 3, pk); tog_en = 1'b0; end
            begin
                while (tog_en) begin
                    @(posedge clk); #1;
                    m_tready = ~m_tready;
                end
            end
        join
        m_tready = 1'b1;
        exp_pkt++;
        @(negedge clk);
        for (int i = 0; i < ex.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== ex[i]) begin n_fail++; $display("FAIL bp_beat%0d: got %h, expected %h", i, (i < got.size()) ? got[i] : 9'h1FF, ex[i]); end
        end
        n_checks++; if (got.size() != ex.size()) begin n_fail++; $display("FAIL bp_len: got %0d beats, expected %0d", got.size(), ex.size()); end
        n_checks++; if (mirror_err != 0) begin n_fail++; $display("FAIL bp_ready_mirror: got %0d mismatching cycles, expected 0", mirror_err); end
        n_checks++; if (pkt_count !== exp_pkt) begin n_fail++; $display("FAIL bp_pkt_count: got %h, expected %h", pkt_count, exp_pkt); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_packet;
        logic [7:0] pk [8];
        int t;
        pk = '{8'h80, 0, 0, 0, 0, 0, 0, 0};
        d[1] = 8'h90; l[1] = 1'b0; v[1] = 1'b1;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (s_tready[1]) break;
        end
        if (t >= 40) begin n_checks++; n_fail++; $display("FAIL midrst_timeout: channel 1 never reached data, required it"); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if ({busy, m_tvalid, m_tlast, s_tready} !== 7'd0) begin n_fail++; $display("FAIL midrst_outputs: got busy=%b v=%b l=%b rdy=%b, expected all 0", busy, m_tvalid, m_tlast, s_tready); end
        n_checks++; if ({grant, pkt_count} !== 18'd0) begin n_fail++; $display("FAIL midrst_regs: got grant=%0d pkt=%h, expected 0/0000", grant, pkt_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_pkt = 16'd0;
        got.delete();
        send_pkt(0, 1, pk);
        v[1] = 1'b0;
        exp_pkt++;
        @(negedge clk);
        n_checks++; if (got.size() != 2 || got[0] !== 9'h0A0 || got[1] !== 9'h180) begin n_fail++; $display("FAIL midrst_regrant: got %0d beats first=%h, expected 2 beats 0A0,180", got.size(), (got.size() > 0) ? got[0] : 9'h1FF); end
        n_checks++; if (pkt_count !== exp_pkt) begin n_fail++; $display("FAIL midrst_pkt_count: got %h, expected %h", pkt_count, exp_pkt); end
        @(posedge clk); #1;
    endtask

    task automatic test_pkt_wrap;
        logic [7:0] pk [8];
        pk = '{8'hC1, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clk);
        force dut.pkt_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.pkt_count;
        send_pkt(2, 1, pk);
        @(negedge clk);
        n_checks++; if (pkt_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h, expected FFFF", pkt_count); end
        @(posedge clk); #1;
        send_pkt(3, 1, pk);
        @(negedge clk);
        n_checks++; if (pkt_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h, expected 0000", pkt_count); end
        n_checks++; if (bad_rdy != 0) begin n_fail++; $display("FAIL non_granted_ready: got %0d offending cycles, expected 0", bad_rdy); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_overflow();
        test_exact_max_len();
        test_set_wins();
        test_back_pressure();
        test_reset_mid_packet();
        test_pkt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
